// File: rtl/pwm_pkg.sv
// Shared encodings for the motor drive pins and the capture state machine.
// The drive localparams and PERIOD_SCALE are also used by the PWM controller.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        BRAKE
    } capture_state_t;

    localparam logic [1:0] DRIVE_OFF   = 2'b00;
    localparam logic [1:0] DRIVE_CW    = 2'b01;
    localparam logic [1:0] DRIVE_ACW   = 2'b10;
    localparam logic [1:0] DRIVE_BRAKE = 2'b11;

    localparam int PERIOD_SCALE = 5000;

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchronizer bringing one asynchronous pin into the clk domain.
// The chain clears to 0 on reset.
module input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Recovers direction, driven time and period of the motor_a/motor_b waveform,
// and flags brake and stopped conditions.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int COUNT_W     = 21,
    parameter int TIMEOUT     = 1275000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               motor_a,
    input  logic               motor_b,
    output logic [COUNT_W-1:0] high_cycles,
    output logic [COUNT_W-1:0] period_cycles,
    output logic               clockwise,
    output logic               meas_valid,
    output logic               braking,
    output logic               stopped
);

    localparam logic [COUNT_W-1:0] TIMEOUT_C = COUNT_W'(TIMEOUT);
    localparam logic [COUNT_W-1:0] ONE_C     = COUNT_W'(1);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v >= TIMEOUT_C) ? TIMEOUT_C : v + ONE_C;
    endfunction

    logic       a_s, b_s;
    logic [1:0] pins_s;
    logic       active_s, active_prev_q;
    logic       rise, fall, timeout;

    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d_i   (motor_a),
        .q_o   (a_s)
    );

    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d_i   (motor_b),
        .q_o   (b_s)
    );

    capture_state_t     state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         dir_q, dir_d;
    logic [COUNT_W-1:0] high_q, high_d;
    logic               stopped_q, stopped_d;
    logic [COUNT_W-1:0] res_high_q, res_high_d;
    logic [COUNT_W-1:0] res_period_q, res_period_d;
    logic               res_cw_q, res_cw_d;
    logic               strobe_q, strobe_d;

    assign pins_s   = {a_s, b_s};
    assign active_s = a_s ^ b_s;
    assign rise     = active_s & ~active_prev_q;
    assign fall     = ~active_s & active_prev_q;
    assign timeout  = (cnt_q == TIMEOUT_C);

    // Priority: brake, then timeout, then edges.
    always_comb begin
        state_d      = state_q;
        cnt_d        = sat_inc(cnt_q);
        dir_d        = dir_q;
        high_d       = high_q;
        stopped_d    = stopped_q;
        res_high_d   = res_high_q;
        res_period_d = res_period_q;
        res_cw_d     = res_cw_q;
        strobe_d     = 1'b0;

        if (pins_s == DRIVE_BRAKE) begin
            state_d = BRAKE;
            cnt_d   = '0;
        end else if (timeout && state_q != HIGH) begin
            // 0% duty or no drive at all: report once, then park in IDLE.
            res_high_d   = '0;
            res_period_d = TIMEOUT_C;
            res_cw_d     = (dir_q == DRIVE_CW);
            strobe_d     = 1'b1;
            stopped_d    = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stopped_q) cnt_d = '0;
                    if (rise) begin
                        state_d   = HIGH;
                        cnt_d     = ONE_C;
                        dir_d     = pins_s;
                        stopped_d = 1'b0;
                    end
                end
                HIGH: begin
                    if (timeout) begin
                        res_high_d   = TIMEOUT_C;
                        res_period_d = TIMEOUT_C;
                        res_cw_d     = (dir_q == DRIVE_CW);
                        strobe_d     = 1'b1;
                        cnt_d        = ONE_C;
                    end else if (fall) begin
                        state_d = LOW;
                        high_d  = cnt_q;
                    end else if (pins_s != dir_q) begin
                        // Direct reversal without an off phase is not a valid period.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                LOW: begin
                    if (rise) begin
                        res_high_d   = high_q;
                        res_period_d = cnt_q;
                        res_cw_d     = (dir_q == DRIVE_CW);
                        strobe_d     = 1'b1;
                        state_d      = HIGH;
                        cnt_d        = ONE_C;
                        dir_d        = pins_s;
                    end
                end
                BRAKE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dir_q         <= DRIVE_OFF;
            high_q        <= '0;
            stopped_q     <= 1'b1;
            res_high_q    <= '0;
            res_period_q  <= '0;
            res_cw_q      <= 1'b0;
            strobe_q      <= 1'b0;
            active_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            high_q        <= high_d;
            stopped_q     <= stopped_d;
            res_high_q    <= res_high_d;
            res_period_q  <= res_period_d;
            res_cw_q      <= res_cw_d;
            strobe_q      <= strobe_d;
            active_prev_q <= active_s;
        end
    end

    // Registered output stage: results move only on the strobe cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cycles   <= '0;
            period_cycles <= '0;
            clockwise     <= 1'b0;
            meas_valid    <= 1'b0;
            braking       <= 1'b0;
            stopped       <= 1'b1;
        end else begin
            meas_valid <= strobe_q;
            braking    <= (state_q == BRAKE);
            stopped    <= stopped_q;
            if (strobe_q) begin
                high_cycles   <= res_high_q;
                period_cycles <= res_period_q;
                clockwise     <= res_cw_q;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected measurements are queued when the
// pins are driven and popped when the DUT strobes meas_valid.
module tb_pwm_capture;

    localparam int CW = 21;
    localparam int TO = 2000;

    typedef struct {
        int h;
        int p;
        int cw;
        int at;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    pins_drv = 2'b00;
    logic          motor_a, motor_b;
    logic [CW-1:0] high_cycles, period_cycles;
    logic          clockwise, meas_valid, braking, stopped;

    assign motor_a = pins_drv[1];
    assign motor_b = pins_drv[0];

    pwm_capture #(.COUNT_W(CW), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .motor_a       (motor_a),
        .motor_b       (motor_b),
        .high_cycles   (high_cycles),
        .period_cycles (period_cycles),
        .clockwise     (clockwise),
        .meas_valid    (meas_valid),
        .braking       (braking),
        .stopped       (stopped)
    );

    initial forever #5 clk = ~clk;

    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   strobe_cnt = 0;
    exp_t sb[$];

    // Reference model of the measured waveform
    int   last_rise = 0;
    int   last_high = 0;
    int   last_cw = 0;
    bit   armed = 1'b0;

    logic [CW-1:0] ref_hc = '0, ref_pc = '0, hc_prev = '0, pc_prev = '0;
    logic          ref_cw = 1'b0, cw_prev = 1'b0, mv_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int h, input int p, input int cw, input int at);
        exp_t e;
        e.h = h; e.p = p; e.cw = cw; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new pin pair and predict the measurement a rising edge completes.
    task automatic go(input logic [1:0] p);
        logic was_act, now_act;
        was_act = pins_drv[1] ^ pins_drv[0];
        now_act = p[1] ^ p[0];
        if (now_act && !was_act) begin
            if (armed) push(last_high, cyc - last_rise, last_cw, cyc + 4);
            last_rise = cyc;
            last_cw   = (p == 2'b01) ? 1 : 0;
        end else if (!now_act && was_act) begin
            last_high = cyc - last_rise;
            armed     = 1'b1;
        end
        pins_drv = p;
    endtask

    task automatic pulse(input logic [1:0] p, input int hi, input int lo);
        go(p);
        wait_cyc(hi);
        go(2'b00);
        wait_cyc(lo);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_high"}, 64'(high_cycles), 64'(0));
        check({tag, "_period"}, 64'(period_cycles), 64'(0));
        check({tag, "_cw"}, 64'(clockwise), 64'(0));
        check({tag, "_valid"}, 64'(meas_valid), 64'(0));
        check({tag, "_braking"}, 64'(braking), 64'(0));
        check({tag, "_stopped"}, 64'(stopped), 64'(1));
    endtask

    // Strobe monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            mv_prev = 1'b0;
        end else begin
            if (meas_valid === 1'b1) begin
                strobe_cnt++;
                check("strobe_width", 64'(mv_prev), 64'(0));
                check("hold_high", 64'(hc_prev), 64'(ref_hc));
                check("hold_period", 64'(pc_prev), 64'(ref_pc));
                check("hold_cw", 64'(cw_prev), 64'(ref_cw));
                check("strobe_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("high_cycles", 64'(high_cycles), 64'(e.h));
                    check("period_cycles", 64'(period_cycles), 64'(e.p));
                    check("clockwise", 64'(clockwise), 64'(e.cw));
                    check("strobe_cycle", 64'(cyc), 64'(e.at));
                end
                ref_hc = high_cycles;
                ref_pc = period_cycles;
                ref_cw = clockwise;
            end
            mv_prev = meas_valid;
        end
        hc_prev = high_cycles;
        pc_prev = period_cycles;
        cw_prev = clockwise;
    end

    initial begin
        int n, saved;

        // Reset held 3 cycles
        wait_cyc(3);
        check_reset_vals("reset");
        reset = 1'b0;
        wait_cyc(5);

        // Clockwise, then anticlockwise, then a minimal 1-cycle pulse
        pulse(2'b01, 498, 502);
        check("stopped_after_rise", 64'(stopped), 64'(0));
        pulse(2'b01, 498, 502);
        pulse(2'b10, 498, 502);
        pulse(2'b10, 498, 502);
        pulse(2'b10, 1, 3);
        pulse(2'b01, 300, 200);

        // Brake in the middle of HIGH
        go(2'b01);
        wait_cyc(100);
        saved = strobe_cnt;
        pins_drv = 2'b11;
        armed = 1'b0;
        wait_cyc(3);
        check("braking_lat_before", 64'(braking), 64'(0));
        wait_cyc(1);
        check("braking_lat_after", 64'(braking), 64'(1));
        wait_cyc(50);
        check("brake_high_held", 64'(high_cycles), 64'(300));
        check("brake_period_held", 64'(period_cycles), 64'(500));
        pins_drv = 2'b00;
        wait_cyc(3);
        check("brake_release_before", 64'(braking), 64'(1));
        wait_cyc(1);
        check("brake_release_after", 64'(braking), 64'(0));
        wait_cyc(100);
        check("brake_no_strobe", 64'(strobe_cnt), 64'(saved));

        // Direct reversal while HIGH
        go(2'b01);
        wait_cyc(500);
        saved = strobe_cnt;
        pins_drv = 2'b10;
        armed = 1'b0;
        wait_cyc(300);
        pins_drv = 2'b00;
        wait_cyc(300);
        check("reversal_no_strobe", 64'(strobe_cnt), 64'(saved));

        // 100% duty timeouts, then 0% duty timeout
        n = cyc;
        pins_drv = 2'b01;
        push(TO, TO, 1, n + 4 + TO);
        push(TO, TO, 1, n + 4 + 2 * TO);
        push(0, TO, 1, n + 4 + 3 * TO);
        wait_cyc(2 * TO + 500);
        pins_drv = 2'b00;
        wait_cyc(TO - 500 + 10);
        check("stopped_after_timeout", 64'(stopped), 64'(1));
        saved = strobe_cnt;
        wait_cyc(2 * TO);
        check("no_repeat_strobe", 64'(strobe_cnt), 64'(saved));
        check("stopped_held", 64'(stopped), 64'(1));

        // Reset in the LOW part of a period
        go(2'b01);
        wait_cyc(498);
        go(2'b00);
        wait_cyc(102);
        saved = strobe_cnt;
        reset = 1'b1;
        wait_cyc(2);
        check_reset_vals("midreset");
        reset = 1'b0;
        armed = 1'b0;
        ref_hc = '0;
        ref_pc = '0;
        ref_cw = 1'b0;
        wait_cyc(200);
        pulse(2'b10, 498, 502);
        check("reset_first_rise_no_strobe", 64'(strobe_cnt), 64'(saved));
        pulse(2'b10, 498, 502);
        push(0, TO, 0, last_rise + 4 + TO);
        wait_cyc(TO + 100);
        check("final_stopped", 64'(stopped), 64'(1));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
